// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the sram-like bus arbiter: owner tags, grant states, access sizes.
// No logic; request fields are carried as one packed struct so the grant mux is a single select.
package sram_bus_arbiter_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner tag FIFO: one bit per accepted request, popped by each bus response.
// Latency: head_owner valid the cycle after push. Backpressure: full is raised; the parent
// stops issuing. Pop while empty is ignored.
module arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic head_owner,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_owner = mem[rd_ptr];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_owner;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch, load/store) to one sram-like slave arbiter with in-order response routing.
// Latency: zero added cycles on request and response paths (combinational select and return).
// Backpressure: a stalled address locks the grant; bus_req drops while the owner FIFO is full.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        err_stray_resp
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t  state;
    logic [SW-1:0] starve;
    logic        sel_vld;
    logic        sel_owner;
    logic        hs;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_owner;
    req_t        inst_r;
    req_t        data_r;
    req_t        bus_r;

    assign inst_r = '{wr: inst_wr, size: inst_size, addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
    assign data_r = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};

    // A locked grant follows only its owner; IDLE arbitrates with data priority unless fetch is starved.
    always_comb begin
        sel_vld   = 1'b0;
        sel_owner = OWNER_INST;
        case (state)
            ARB_LOCK_I: begin
                sel_vld   = inst_req;
                sel_owner = OWNER_INST;
            end
            ARB_LOCK_D: begin
                sel_vld   = data_req;
                sel_owner = OWNER_DATA;
            end
            default: begin
                if (data_req && !(starve == SW'(STARVE_LIMIT) && inst_req)) begin
                    sel_vld   = 1'b1;
                    sel_owner = OWNER_DATA;
                end else if (inst_req) begin
                    sel_vld   = 1'b1;
                    sel_owner = OWNER_INST;
                end
            end
        endcase
    end

    assign bus_r     = (sel_owner == OWNER_DATA) ? data_r : inst_r;
    assign bus_wr    = bus_r.wr;
    assign bus_size  = bus_r.size;
    assign bus_addr  = bus_r.addr;
    assign bus_wstrb = bus_r.wstrb;
    assign bus_wdata = bus_r.wdata;

    assign bus_req      = resetn && sel_vld && !fifo_full;
    assign hs           = bus_req && bus_addr_ok;
    assign inst_addr_ok = hs && (sel_owner == OWNER_INST);
    assign data_addr_ok = hs && (sel_owner == OWNER_DATA);

    assign inst_data_ok = resetn && bus_data_ok && !fifo_empty && (head_owner == OWNER_INST);
    assign data_data_ok = resetn && bus_data_ok && !fifo_empty && (head_owner == OWNER_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (hs),
        .push_owner (sel_owner),
        .pop        (bus_data_ok),
        .head_owner (head_owner),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ARB_IDLE;
            starve         <= '0;
            err_stray_resp <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus_req && !bus_addr_ok) begin
                        state <= (sel_owner == OWNER_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
                    end
                end
                default: begin
                    // Owner dropping req is a flush cancel; release the lock either way.
                    if (!sel_vld || bus_addr_ok) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase

            if (inst_addr_ok) begin
                starve <= '0;
            end else if (data_addr_ok && inst_req && starve != SW'(STARVE_LIMIT)) begin
                starve <= starve + 1'b1;
            end

            if (bus_data_ok && fifo_empty) begin
                err_stray_resp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: fetch, priority, lock, starvation, full, stray, reset.
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err_stray_resp;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .err_stray_resp(err_stray_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic starve_pat [8];

    initial begin
        starve_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = '0; inst_wstrb = 4'hf; inst_wdata = '0;
        data_req = 0; data_wr = 1; data_size = SIZE_H; data_addr = '0; data_wstrb = 4'h3; data_wdata = 32'h1234_5678;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

        // Reset: outputs forced low even with a live request
        inst_req = 1; bus_addr_ok = 1;
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_err", err_stray_resp, 0);
        inst_req = 0; bus_addr_ok = 0;
        #10 resetn = 1'b1;
        step();

        // 1. Fetch only
        inst_req = 1; inst_addr = 32'h1c00_0000; bus_addr_ok = 1;
        #1;
        chk("t1_bus_req", bus_req, 1);
        chk("t1_bus_addr", bus_addr, 32'h1c00_0000);
        chk("t1_bus_size", bus_size, SIZE_W);
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        step();
        inst_req = 0; bus_addr_ok = 0;
        step();
        bus_data_ok = 1; bus_rdata = 32'h0280_0c0c;
        #1;
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h0280_0c0c);
        chk("t1_data_data_ok", data_data_ok, 0);
        step();
        bus_data_ok = 0;

        // 2. Simultaneous requests: data first, then fetch; responses in order D, I
        inst_req = 1; inst_addr = 32'h1c00_0004;
        data_req = 1; data_addr = 32'h8000_0010; bus_addr_ok = 1;
        #1;
        chk("t2_bus_addr_d", bus_addr, 32'h8000_0010);
        chk("t2_bus_wr_d", bus_wr, 1);
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok0", inst_addr_ok, 0);
        step();
        data_req = 0;
        #1;
        chk("t2_bus_addr_i", bus_addr, 32'h1c00_0004);
        chk("t2_inst_addr_ok", inst_addr_ok, 1);
        step();
        inst_req = 0; bus_addr_ok = 0;
        bus_data_ok = 1; bus_rdata = 32'haaaa_0001;
        #1;
        chk("t2_resp1_data", data_data_ok, 1);
        chk("t2_resp1_inst", inst_data_ok, 0);
        chk("t2_data_rdata", data_rdata, 32'haaaa_0001);
        step();
        bus_rdata = 32'hbbbb_0002;
        #1;
        chk("t2_resp2_inst", inst_data_ok, 1);
        chk("t2_resp2_data", data_data_ok, 0);
        step();
        bus_data_ok = 0;

        // 3. Lock: fetch stalled three cycles while data arrives
        inst_req = 1; inst_addr = 32'h1c00_0008;
        #1;
        chk("t3_c1_bus_addr", bus_addr, 32'h1c00_0008);
        step();
        data_req = 1; data_addr = 32'h8000_0020;
        #1;
        chk("t3_c2_bus_addr", bus_addr, 32'h1c00_0008);
        chk("t3_c2_data_addr_ok", data_addr_ok, 0);
        step();
        #1;
        chk("t3_c3_bus_addr", bus_addr, 32'h1c00_0008);
        step();
        bus_addr_ok = 1;
        #1;
        chk("t3_c4_inst_addr_ok", inst_addr_ok, 1);
        chk("t3_c4_data_addr_ok", data_addr_ok, 0);
        step();
        inst_req = 0;
        #1;
        chk("t3_next_bus_addr", bus_addr, 32'h8000_0020);
        chk("t3_next_data_addr_ok", data_addr_ok, 1);
        step();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        #1;
        chk("t3_resp_inst", inst_data_ok, 1);
        step();
        #1;
        chk("t3_resp_data", data_data_ok, 1);
        step();
        bus_data_ok = 0;

        // 4. Starvation: D,D,D,I,D,D,D,I with one response per cycle keeping the FIFO shallow
        data_req = 1; inst_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t4_grant%0d_d", i), data_addr_ok, starve_pat[i]);
            chk($sformatf("t4_grant%0d_i", i), inst_addr_ok, !starve_pat[i]);
            step();
            bus_data_ok = 1;
        end
        data_req = 0; inst_req = 0; bus_addr_ok = 0;
        #1;
        chk("t4_last_resp_inst", inst_data_ok, 1);
        step();
        bus_data_ok = 0;

        // 5. Full, then drain, then a stray response
        data_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_accept%0d", i), data_addr_ok, 1);
            step();
        end
        #1;
        chk("t5_full_bus_req", bus_req, 0);
        chk("t5_full_addr_ok", data_addr_ok, 0);
        bus_data_ok = 1;
        #1;
        chk("t5_full_pop_bus_req", bus_req, 0);
        chk("t5_full_pop_data_ok", data_data_ok, 1);
        step();
        bus_data_ok = 0;
        #1;
        chk("t5_reenable_bus_req", bus_req, 1);
        chk("t5_reenable_addr_ok", data_addr_ok, 1);
        step();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_drain%0d", i), data_data_ok, 1);
            step();
        end
        #1;
        chk("t5_stray_data_ok", data_data_ok, 0);
        chk("t5_stray_inst_ok", inst_data_ok, 0);
        chk("t5_err_before", err_stray_resp, 0);
        step();
        bus_data_ok = 0;
        chk("t5_err_set", err_stray_resp, 1);
        step();
        chk("t5_err_sticky", err_stray_resp, 1);

        // 6. Reset with two requests outstanding
        data_req = 1; bus_addr_ok = 1;
        step();
        step();
        #2 resetn = 1'b0;
        bus_data_ok = 1;
        #1;
        chk("t6_rst_bus_req", bus_req, 0);
        chk("t6_rst_addr_ok", data_addr_ok, 0);
        chk("t6_rst_data_ok", data_data_ok, 0);
        chk("t6_rst_err", err_stray_resp, 0);
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        step();
        #3 resetn = 1'b1;
        step();
        bus_data_ok = 1; bus_rdata = 32'hdead_beef;
        #1;
        chk("t6_stray_data_ok", data_data_ok, 0);
        chk("t6_stray_inst_ok", inst_data_ok, 0);
        step();
        bus_data_ok = 0;
        chk("t6_err_set", err_stray_resp, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
